// File: rtl/gate_pkg.sv
// Shared definitions for the gate library: op encodings, the legality check
// and the sweep FSM state type.
package gate_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_XNOR;
  endfunction

endpackage

// File: rtl/nary_gate.sv
// Combinational N-input reference gate: reduction AND/OR/XOR and complements.
// With N_IN=1 the AND/OR forms are buffers and NAND/NOR are inverters.
module nary_gate
  import gate_pkg::*;
#(
  parameter int N_IN = 2
) (
  input  logic [N_IN-1:0] a,
  input  logic [2:0]      op,
  output logic            y
);

  always_comb begin
    // NOTE: y gets a default before the case so every path assigns it and no latch is inferred.
    y = 1'b0;
    case (op)
      OP_AND:  y = &a;
      OP_OR:   y = |a;
      OP_NAND: y = ~&a;
      OP_NOR:  y = ~|a;
      OP_XOR:  y = ^a;
      OP_XNOR: y = ~^a;
      default: y = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive bring-up harness: sweeps every input vector onto an external gate
// and compares its response against the internal reference gate.
module gate_sweep_checker
  import gate_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            op_err,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec
);

  localparam int              CW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   WAIT_LAST = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;

  state_e          state_q;
  logic [CW-1:0]   wait_q;
  logic [2:0]      op_q;
  logic [N_IN-1:0] stim_q;
  logic            busy_q;
  logic            done_q;
  logic            op_err_q;
  logic [N_IN:0]   err_q;
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;

  logic [N_IN-1:0] stim_d;
  logic [N_IN:0]   err_count_d;
  logic            ref_y;
  logic            mismatch;

  nary_gate #(.N_IN(N_IN)) u_ref (
    .a  (stim_q),
    .op (op_q),
    .y  (ref_y)
  );

  assign stim_d      = stim_q + 1'b1;
  assign err_count_d = err_q + (N_IN+1)'(1);
  assign mismatch    = dut_y ^ ref_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      op_q         <= OP_AND;
      stim_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      op_err_q     <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every branch reads the pre-edge register values.
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_q <= '0;
            if (op_legal(op)) begin
              op_q         <= op;
              fail_valid_q <= 1'b0;
              fail_vec_q   <= '0;
              done_q       <= 1'b0;
              op_err_q     <= 1'b0;
              stim_q       <= '0;
              wait_q       <= '0;
              busy_q       <= 1'b1;
              state_q      <= ST_SETTLE;
            end else begin
              // Illegal op finishes at once; stim keeps whatever it held.
              done_q   <= 1'b1;
              op_err_q <= 1'b1;
              state_q  <= ST_DONE;
            end
          end
        end

        ST_SETTLE: begin
          if (abort) begin
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= ST_CHECK;
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end

        ST_CHECK: begin
          // Abort outranks a sweep completing on this same edge.
          if (abort) begin
            stim_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            if (mismatch) begin
              err_q <= err_count_d;
              if (!fail_valid_q) begin
                fail_valid_q <= 1'b1;
                fail_vec_q   <= stim_q;
              end
            end
            if (stim_q == VEC_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              stim_q  <= stim_d;
              wait_q  <= '0;
              state_q <= ST_SETTLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign op_err     = op_err_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign pass       = done_q & ~op_err_q & (err_q == '0);

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: two instances (N_IN=2/SETTLE=1, N_IN=3/SETTLE=2)
// driven from a directed table, random sweeps and hand-written abort/reset sequences.
module tb_gate_sweep_checker;
  import gate_pkg::*;

  localparam int NA = 2, SA = 1;
  localparam int NB = 3, SB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0, abort = 1'b0;
  logic [2:0] op = 3'd0;
  int         sel = 0;

  // External gate under test: a chosen function with optional per-vector faults.
  logic [2:0]   gut_op = OP_AND;
  logic         gut_tie0 = 1'b0;
  logic [255:0] flip = '0;

  logic start_a, start_b, abort_a, abort_b, dut_y_a, dut_y_b;
  logic [NA-1:0] stim_a, fvec_a;
  logic [NB-1:0] stim_b, fvec_b;
  logic [NA:0]   err_a;
  logic [NB:0]   err_b;
  logic busy_a, done_a, pass_a, operr_a, fvalid_a;
  logic busy_b, done_b, pass_b, operr_b, fvalid_b;

  logic [7:0] m_stim, m_fvec;
  logic [8:0] m_err;
  logic       m_busy, m_done, m_pass, m_operr, m_fvalid;

  int total = 0;
  int bad = 0;

  function automatic logic ref_gate(input logic [2:0] f, input int v, input int n);
    int ones = 0;
    for (int i = 0; i < n; i++) if (((v >> i) & 1) == 1) ones++;
    case (f)
      3'd0:    return ones == n;
      3'd1:    return ones > 0;
      3'd2:    return ones != n;
      3'd3:    return ones == 0;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign abort_a = abort && (sel == 0);
  assign abort_b = abort && (sel == 1);
  assign dut_y_a = gut_tie0 ? 1'b0 : (ref_gate(gut_op, int'(stim_a), NA) ^ flip[stim_a]);
  assign dut_y_b = gut_tie0 ? 1'b0 : (ref_gate(gut_op, int'(stim_b), NB) ^ flip[stim_b]);

  gate_sweep_checker #(.N_IN(NA), .SETTLE(SA)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .op(op),
    .dut_y(dut_y_a), .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .op_err(operr_a), .err_count(err_a), .fail_valid(fvalid_a), .fail_vec(fvec_a)
  );

  gate_sweep_checker #(.N_IN(NB), .SETTLE(SB)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .op(op),
    .dut_y(dut_y_b), .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .op_err(operr_b), .err_count(err_b), .fail_valid(fvalid_b), .fail_vec(fvec_b)
  );

  always_comb begin
    if (sel == 0) begin
      m_stim = 8'(stim_a);  m_fvec = 8'(fvec_a);  m_err = 9'(err_a);
      m_busy = busy_a;      m_done = done_a;      m_pass = pass_a;
      m_operr = operr_a;    m_fvalid = fvalid_a;
    end else begin
      m_stim = 8'(stim_b);  m_fvec = 8'(fvec_b);  m_err = 9'(err_b);
      m_busy = busy_b;      m_done = done_b;      m_pass = pass_b;
      m_operr = operr_b;    m_fvalid = fvalid_b;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int           sel;
    logic [2:0]   op;
    logic [2:0]   gut_op;
    logic         tie0;
    logic [255:0] flip;
    int           exp_err;
    logic         exp_fvalid;
    int           exp_fvec;
    logic         exp_pass;
    logic         exp_op_err;
    int           exp_lat;
  } vec_t;

  function automatic vec_t mk(input int s, input logic [2:0] o, input logic [2:0] g,
                              input logic t0, input logic [255:0] f, input int e,
                              input logic fv, input int fvec, input logic p,
                              input logic oe, input int lat);
    vec_t r;
    r.sel = s; r.op = o; r.gut_op = g; r.tie0 = t0; r.flip = f;
    r.exp_err = e; r.exp_fvalid = fv; r.exp_fvec = fvec; r.exp_pass = p;
    r.exp_op_err = oe; r.exp_lat = lat;
    return r;
  endfunction

  // Expected results straight from the rules: count disagreeing vectors, note the first.
  function automatic vec_t model(input vec_t t);
    vec_t r = t;
    int n = (t.sel == 0) ? NA : NB;
    int s = (t.sel == 0) ? SA : SB;
    logic gy;
    r.exp_err = 0; r.exp_fvalid = 1'b0; r.exp_fvec = 0;
    if (t.op > 3'd5) begin
      r.exp_op_err = 1'b1; r.exp_pass = 1'b0; r.exp_lat = 0;
      return r;
    end
    for (int v = 0; v < (1 << n); v++) begin
      gy = t.tie0 ? 1'b0 : (ref_gate(t.gut_op, v, n) ^ t.flip[v]);
      if (gy != ref_gate(t.op, v, n)) begin
        if (!r.exp_fvalid) begin
          r.exp_fvalid = 1'b1;
          r.exp_fvec = v;
        end
        r.exp_err++;
      end
    end
    r.exp_op_err = 1'b0;
    r.exp_pass = (r.exp_err == 0);
    r.exp_lat = (s + 1) * (1 << n);
    return r;
  endfunction

  // Start a sweep and follow it: exp_lat counts edges after the accepting edge
  // until done is visible (0 means done is already high right after accept).
  task automatic run_vec(input vec_t t, input string name);
    int n, s, lat;
    bit seq_ok;
    logic [7:0] stim_before;
    n = (t.sel == 0) ? NA : NB;
    s = (t.sel == 0) ? SA : SB;
    @(negedge clk);
    sel = t.sel; gut_op = t.gut_op; gut_tie0 = t.tie0; flip = t.flip;
    #1;
    stim_before = m_stim;
    op = t.op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    seq_ok = 1'b1;
    while (!m_done && lat < 200) begin
      if (m_stim != 8'(lat / (s + 1)) || !m_busy) seq_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, t.exp_lat);
    check({name, "_op_err"}, m_operr, t.exp_op_err);
    check({name, "_pass"}, m_pass, t.exp_pass);
    check({name, "_err_count"}, m_err, t.exp_err);
    if (t.exp_op_err) begin
      check({name, "_stim_kept"}, m_stim, stim_before);
      check({name, "_busy_low"}, m_busy, 0);
      @(negedge clk);
      check({name, "_done_held"}, {m_done, m_busy}, 2'b10);
    end else begin
      check({name, "_stim_sequence"}, seq_ok, 1);
      check({name, "_stim_last"}, m_stim, (1 << n) - 1);
      check({name, "_fail_valid"}, m_fvalid, t.exp_fvalid);
      check({name, "_fail_vec"}, m_fvec, t.exp_fvec);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, "_a"}, {stim_a, busy_a, done_a, pass_a, operr_a, err_a, fvalid_a, fvec_a}, 0);
    check({name, "_b"}, {stim_b, busy_b, done_b, pass_b, operr_b, err_b, fvalid_b, fvec_b}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;
    int   lat;

    tbl[0] = mk(0, OP_NOR,  OP_NOR,  1'b0, 256'h0, 0, 1'b0, 0, 1'b1, 1'b0, 8);
    tbl[1] = mk(0, OP_NOR,  OP_NAND, 1'b0, 256'h0, 2, 1'b1, 1, 1'b0, 1'b0, 8);
    tbl[2] = mk(0, OP_AND,  OP_AND,  1'b0, 256'h8, 1, 1'b1, 3, 1'b0, 1'b0, 8);
    tbl[3] = mk(0, 3'd6,    OP_AND,  1'b0, 256'h0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    tbl[4] = mk(1, OP_XOR,  OP_XOR,  1'b1, 256'h0, 4, 1'b1, 1, 1'b0, 1'b0, 24);
    tbl[5] = mk(1, OP_OR,   OP_OR,   1'b0, 256'h0, 0, 1'b0, 0, 1'b1, 1'b0, 24);
    tbl[6] = mk(1, 3'd7,    OP_OR,   1'b0, 256'h0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    tbl[7] = mk(0, OP_XNOR, OP_XNOR, 1'b0, 256'hF, 4, 1'b1, 0, 1'b0, 1'b0, 8);

    #1;
    check_reset("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 10; i++) begin
      rv.sel = $urandom_range(0, 1);
      rv.op = 3'($urandom_range(0, 7));
      rv.gut_op = 3'($urandom_range(0, 5));
      rv.tie0 = ($urandom_range(0, 5) == 0);
      for (int w = 0; w < 8; w++) rv.flip[w*32 +: 32] = $urandom & $urandom;
      run_vec(model(rv), $sformatf("rand%0d", i));
    end

    // Faulty gate on vector 01; an illegal start mid-sweep must be ignored, then abort at stim=10.
    @(negedge clk);
    sel = 0; gut_op = OP_AND; gut_tie0 = 1'b0; flip = 256'h2; op = OP_AND; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = OP_AND;
    check("ignored_start", {m_busy, m_done, m_operr}, 3'b100);
    lat = 0;
    while (m_stim != 8'd2 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("abort_reach_stim2", m_stim, 2);
    check("abort_err_before", m_err, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy_done", {m_busy, m_done}, 2'b00);
    check("abort_err_kept", m_err, 1);
    check("abort_stim_zero", m_stim, 0);
    check("abort_fail_kept", {m_fvalid, m_fvec}, {1'b1, 8'd1});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_noeffect", {m_busy, m_done, m_err, m_stim}, {1'b0, 1'b0, 9'd1, 8'd0});

    // Abort on the final CHECK edge must win over completion.
    @(negedge clk);
    sel = 0; gut_op = OP_OR; flip = '0; op = OP_OR; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (m_stim != 8'd3 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("prio_reach_stim3", m_stim, 3);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("prio_abort_wins", {m_busy, m_done, m_pass, m_stim}, {3'b000, 8'd0});

    // Asynchronous reset mid-sweep, then a clean sweep afterwards.
    @(negedge clk);
    sel = 1; gut_tie0 = 1'b1; op = OP_XOR; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("rst_midsweep_active", {m_busy, m_err != 9'd0}, 2'b11);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(model(mk(1, OP_NAND, OP_NAND, 1'b0, 256'h0, 0, 1'b0, 0, 1'b0, 1'b0, 0)), "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
